// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 capture path.
// Holds the default frame geometry, frame-buffer sizing, the capture
// state encoding and the RGB565 pixel payload type.
package cam_pkg;

   localparam int unsigned H_PIX_DEF   = 320;
   localparam int unsigned V_LINES_DEF = 240;
   localparam int unsigned FB_DEPTH    = 76800;
   localparam int unsigned FB_ADDR_W   = 17;

   typedef enum logic [1:0] {
      SYNC   = 2'd0,
      BLANK  = 2'd1,
      ACTIVE = 2'd2
   } cam_state_e;

   // RGB565 pixel as assembled from two camera bytes
   typedef struct packed {
      logic [7:0] hi;
      logic [7:0] lo;
   } cam_pix_t;

endpackage

// File: rtl/cam_edge_det.sv
// Single-signal edge detector: registers the input once and flags
// rising/falling transitions relative to the previous sample.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   sig_i        - sampled signal
//   rise_c_o     - combinational, high in the first cycle sig_i reads 1
//   fall_c_o     - combinational, high in the first cycle sig_i reads 0
module cam_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic sig_i,
   output logic rise_c_o,
   output logic fall_c_o
);

   logic sig_q;

   // previous-sample register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sig_q <= 1'b0;
      else       sig_q <= sig_i;
   end

   assign rise_c_o = sig_i & ~sig_q;
   assign fall_c_o = ~sig_i & sig_q;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 frame capture: pairs camera bytes into RGB565 pixels and writes
// them to a frame buffer at row*H_PIX+col.
// Optional build macro: CAM_ERR_CHECK_EN enables the line/frame length checker.
// Ports:
//   clk, reset        - camera PCLK, asynchronous active-high reset
//   vsync, href, data - camera sync and pixel byte inputs
//   we, wAddr, wData  - registered frame-buffer write port
//   frame_done        - one-cycle pulse when a captured frame ends
//   err_line          - sticky: a line ended with a pixel count other than H_PIX
//   err_frame         - sticky: a frame ended with a line count other than V_LINES
module ov7670_capture
   import cam_pkg::*;
#(
   parameter int unsigned H_PIX   = H_PIX_DEF,
   parameter int unsigned V_LINES = V_LINES_DEF,
   parameter int unsigned ADDR_W  = FB_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vsync,
   input  logic              href,
   input  logic [7:0]        data,
   output logic              we,
   output logic [ADDR_W-1:0] wAddr,
   output logic [15:0]       wData,
   output logic              frame_done,
   output logic              err_line,
   output logic              err_frame
);

   // counters hold one value past the limit so over-long lines/frames are visible
   localparam int unsigned COL_W = $clog2(H_PIX + 2);
   localparam int unsigned ROW_W = $clog2(V_LINES + 2);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_PIX * V_LINES - 1);
   localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIX);

   cam_state_e        state_q, state_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic              phase_q, phase_d;
   logic              line_q, line_d;
   logic [7:0]        hi_q, hi_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   cam_pix_t          wdata_q, wdata_d;
   logic              done_q, done_d;

   logic href_rise_c, href_fall_c, vsync_rise_c, vsync_fall_c;
   logic frame_start_c, frame_end_c, line_end_c;

   cam_edge_det u_href_edge (
      .clk      (clk),
      .reset    (reset),
      .sig_i    (href),
      .rise_c_o (href_rise_c),
      .fall_c_o (href_fall_c)
   );

   cam_edge_det u_vsync_edge (
      .clk      (clk),
      .reset    (reset),
      .sig_i    (vsync),
      .rise_c_o (vsync_rise_c),
      .fall_c_o (vsync_fall_c)
   );

   // in BLANK vsync was high last cycle, so a low sample is always a fall;
   // in ACTIVE vsync was low last cycle, so a high sample is always a rise
   assign frame_start_c = (state_q == BLANK)  & vsync_fall_c;
   assign frame_end_c   = (state_q == ACTIVE) & vsync_rise_c;
   // line_q ignores an href that was already high when the frame opened
   assign line_end_c    = (state_q == ACTIVE) & ~vsync_rise_c & line_q & href_fall_c;

   // next-state, pixel assembly and address generation
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      phase_d = phase_q;
      line_d  = line_q;
      hi_d    = hi_q;
      addr_d  = addr_q;
      base_d  = base_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      done_d  = 1'b0;

      unique case (state_q)
         SYNC: begin
            if (vsync) state_d = BLANK;
         end
         BLANK: begin
            if (frame_start_c) begin
               state_d = ACTIVE;
               col_d   = '0;
               row_d   = '0;
               phase_d = 1'b0;
               line_d  = 1'b0;
               addr_d  = '0;
               base_d  = '0;
            end
         end
         ACTIVE: begin
            if (frame_end_c) begin
               // frame end wins over any byte on the same cycle
               state_d = BLANK;
               done_d  = 1'b1;
               phase_d = 1'b0;
               line_d  = 1'b0;
            end else if (href && (line_q || href_rise_c)) begin
               line_d  = 1'b1;
               phase_d = ~phase_q;
               if (!phase_q) begin
                  hi_d = data;
               end else begin
                  if ((col_q < COL_W'(H_PIX)) && (row_q < ROW_W'(V_LINES))) begin
                     we_d       = 1'b1;
                     waddr_d    = addr_q;
                     wdata_d.hi = hi_q;
                     wdata_d.lo = data;
                     if (addr_q != LAST_ADDR) addr_d = addr_q + ADDR_W'(1);
                  end
                  if (col_q <= COL_W'(H_PIX)) col_d = col_q + COL_W'(1);
               end
            end else if (line_end_c) begin
               // dangling half-pixel is dropped; short lines realign to the next row base
               col_d   = '0;
               phase_d = 1'b0;
               line_d  = 1'b0;
               if (row_q <= ROW_W'(V_LINES)) row_d = row_q + ROW_W'(1);
               if (row_q < ROW_W'(V_LINES - 1)) begin
                  base_d = base_q + LINE_STEP;
                  addr_d = base_q + LINE_STEP;
               end
            end
         end
         default: state_d = SYNC;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= SYNC;
         col_q   <= '0;
         row_q   <= '0;
         phase_q <= 1'b0;
         line_q  <= 1'b0;
         hi_q    <= '0;
         addr_q  <= '0;
         base_q  <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         phase_q <= phase_d;
         line_q  <= line_d;
         hi_q    <= hi_d;
         addr_q  <= addr_d;
         base_q  <= base_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
      end
   end

   assign we         = we_q;
   assign wAddr      = waddr_q;
   assign wData      = wdata_q;
   assign frame_done = done_q;

`ifdef CAM_ERR_CHECK_EN
   logic err_line_q, err_frame_q;

   // sticky length checks, cleared when a new frame opens
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_line_q  <= 1'b0;
         err_frame_q <= 1'b0;
      end else if (frame_start_c) begin
         err_line_q  <= 1'b0;
         err_frame_q <= 1'b0;
      end else begin
         if (line_end_c && (col_q != COL_W'(H_PIX)))    err_line_q  <= 1'b1;
         if (frame_end_c && (row_q != ROW_W'(V_LINES))) err_frame_q <= 1'b1;
      end
   end

   assign err_line  = err_line_q;
   assign err_frame = err_frame_q;
`else
   assign err_line  = 1'b0;
   assign err_frame = 1'b0;
`endif

endmodule

// File: tb/tb_ov7670_capture.sv
// Self-checking bench for ov7670_capture on a reduced 32x24 frame.
module tb_ov7670_capture;

   localparam int H = 32;
   localparam int V = 24;
`ifdef CAM_ERR_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct {
      int          cyc;
      logic [16:0] addr;
      logic [15:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, vsync, href;
   logic [7:0]  data;
   logic        we, frame_done, err_line, err_frame;
   logic [16:0] wAddr;
   logic [15:0] wData;

   ov7670_capture #(.H_PIX(H), .V_LINES(V), .ADDR_W(17)) dut (
      .clk        (clk),
      .reset      (reset),
      .vsync      (vsync),
      .href       (href),
      .data       (data),
      .we         (we),
      .wAddr      (wAddr),
      .wData      (wData),
      .frame_done (frame_done),
      .err_line   (err_line),
      .err_frame  (err_frame)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   // reference model state
   exp_t       exp_q[$];
   int         dq[$];
   logic [7:0] pre_q[$];
   bit         capturing = 1'b0;
   bit         bad_line  = 1'b0;
   bit         inc_mode  = 1'b0;
   int         mrow = 0;
   int         bcnt = 0;
   int         drv_cyc = 0;
   int         t_pre = 0;

   // observations
   int          nwr = 0, ndone = 0;
   bit          first_pending = 1'b0;
   logic [16:0] first_addr = '0, last_addr = '0;
   logic [15:0] first_data = '0;
   int          first_cyc = 0;
   exp_t        ce;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   // per-cycle comparison against the model's expected writes and pulses
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         ce = exp_q.pop_front();
         checks++; errors++;
         $display("FAIL missed_write@%0d: got nothing want addr=%0d data=%h", ce.cyc, ce.addr, ce.data);
      end
      checks++;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         ce = exp_q.pop_front();
         if (we !== 1'b1 || wAddr !== ce.addr || wData !== ce.data) begin
            errors++;
            $display("FAIL write@%0d: got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                     cyc, we, wAddr, wData, ce.addr, ce.data);
         end
      end else if (we !== 1'b0) begin
         errors++;
         $display("FAIL stray_write@%0d: got we=%b addr=%0d want we=0", cyc, we, wAddr);
      end
      checks++;
      if (dq.size() > 0 && dq[0] == cyc) begin
         void'(dq.pop_front());
         if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL frame_done@%0d: got %b want 1", cyc, frame_done);
         end
      end else if (frame_done !== 1'b0) begin
         errors++;
         $display("FAIL frame_done@%0d: got %b want 0", cyc, frame_done);
      end
`ifndef CAM_ERR_CHECK_EN
      checks++;
      if (err_line !== 1'b0 || err_frame !== 1'b0) begin
         errors++;
         $display("FAIL err_tied@%0d: got line=%b frame=%b want 0 0", cyc, err_line, err_frame);
      end
`endif
      if (we === 1'b1) begin
         nwr++;
         last_addr = wAddr;
         if (first_pending) begin
            first_addr    = wAddr;
            first_data    = wData;
            first_cyc     = cyc;
            first_pending = 1'b0;
         end
      end
      if (frame_done === 1'b1) ndone++;
   end

   task automatic drv(input logic v, input logic h, input logic [7:0] d);
      @(negedge clk);
      vsync   = v;
      href    = h;
      data    = d;
      drv_cyc = cyc;
   endtask

   task automatic get_byte(output logic [7:0] b, output bit from_pre);
      from_pre = 1'b0;
      if (pre_q.size() > 0) begin
         b = pre_q.pop_front();
         from_pre = 1'b1;
      end else if (inc_mode) begin
         b = bcnt[7:0];
         bcnt++;
      end else begin
         b = 8'($urandom);
      end
   endtask

   // drive n line bytes; every odd byte completes pixel i/2 of the current row
   task automatic send_bytes(input int n);
      logic [7:0] b, hi;
      bit         fp;
      exp_t       e;
      hi = '0;
      for (int i = 0; i < n; i++) begin
         get_byte(b, fp);
         drv(1'b0, 1'b1, b);
         if (fp) t_pre = drv_cyc;
         if ((i % 2 == 1) && capturing && (mrow < V) && (i / 2 < H)) begin
            e.cyc  = drv_cyc + 1;
            e.addr = 17'(mrow * H + i / 2);
            e.data = {hi, b};
            exp_q.push_back(e);
         end
         hi = b;
      end
   endtask

   task automatic send_line(input int n, input int gap);
      send_bytes(n);
      if (capturing && (n / 2 != H)) bad_line = 1'b1;
      repeat (gap) drv(1'b0, 1'b0, 8'h00);
      if (capturing && n > 0) mrow++;
   endtask

   // partial line whose last byte coincides with vsync rising
   task automatic abort_line(input int k);
      logic [7:0] b;
      bit         fp;
      send_bytes(k);
      get_byte(b, fp);
      drv(1'b1, 1'b1, b);
      if (capturing) dq.push_back(drv_cyc + 1);
      capturing = 1'b0;
   endtask

   // vsync high-then-low; closes any open frame and opens the next
   task automatic frame_start();
      bit was;
      was = capturing;
      drv(1'b1, 1'b0, 8'h00);
      if (was) dq.push_back(drv_cyc + 1);
      capturing = 1'b0;
      drv(1'b1, 1'b0, 8'h00);
      drv(1'b1, 1'b0, 8'h00);
      if (was) begin
         chk("frame_end_err_line", 32'(err_line), 32'(ERR_EN & bad_line));
         chk("frame_end_err_frame", 32'(err_frame), 32'(ERR_EN & (mrow != V)));
      end
      drv(1'b0, 1'b0, 8'h00);
      drv(1'b0, 1'b0, 8'h00);
      capturing = 1'b1;
      mrow      = 0;
      bad_line  = 1'b0;
   endtask

   task automatic do_reset();
      drv(1'b0, 1'b0, 8'h00);
      @(negedge clk);
      reset     = 1'b1;
      capturing = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   initial begin
      int nw0, nd0, nl, nb;
      reset = 1'b1; vsync = 1'b0; href = 1'b0; data = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_we", 32'(we), 0);
      chk("rst_waddr", 32'(wAddr), 0);
      chk("rst_wdata", 32'(wData), 0);
      chk("rst_done", 32'(frame_done), 0);
      chk("rst_err_line", 32'(err_line), 0);
      chk("rst_err_frame", 32'(err_frame), 0);
      reset = 1'b0;

      // full frame of incrementing bytes
      frame_start();
      inc_mode = 1'b1; bcnt = 0;
      nw0 = nwr; first_pending = 1'b1;
      for (int r = 0; r < V; r++) send_line(2 * H, 3);
      nd0 = ndone;
      frame_start();
      chk("A_writes", 32'(nwr - nw0), 768);
      chk("A_first_addr", 32'(first_addr), 0);
      chk("A_first_data", 32'(first_data), 32'h0001);
      chk("A_last_addr", 32'(last_addr), 767);
      chk("A_done_pulses", 32'(ndone - nd0), 1);

      // 0xF8,0x1F pixel latency, then an over-long line with a trailing byte
      inc_mode = 1'b0;
      pre_q.push_back(8'hF8);
      pre_q.push_back(8'h1F);
      first_pending = 1'b1;
      send_line(2 * H, 3);
      chk("B_f81f_data", 32'(first_data), 32'hF81F);
      chk("B_f81f_latency", 32'(first_cyc - t_pre), 1);
      chk("B_f81f_addr", 32'(first_addr), 0);
      nw0 = nwr;
      send_line(2 * (H + 1) + 1, 3);
      chk("B_long_writes", 32'(nwr - nw0), 32);
      chk("B_err_line", 32'(err_line), 32'(ERR_EN));
      for (int r = 2; r < V; r++) send_line(2 * H, 3);
      frame_start();

      // reset mid-frame, stimulus resumes without vsync
      for (int r = 0; r < V / 2; r++) send_line(2 * H, 3);
      do_reset();
      nw0 = nwr;
      for (int r = V / 2; r < V; r++) send_line(2 * H, 3);
      chk("C_no_writes", 32'(nwr - nw0), 0);
      first_pending = 1'b1;
      frame_start();

      // frame cut short by vsync with href still high
      for (int r = 0; r < 20; r++) send_line(2 * H, 3);
      chk("D_first_addr", 32'(first_addr), 0);
      nd0 = ndone;
      abort_line(7);
      drv(1'b1, 1'b0, 8'h00);
      nw0 = nwr;
      repeat (4) drv(1'b1, 1'b0, 8'h00);
      chk("D_done_pulses", 32'(ndone - nd0), 1);
      chk("D_post_writes", 32'(nwr - nw0), 0);
      chk("D_err_frame", 32'(err_frame), 32'(ERR_EN));
      chk("D_err_line", 32'(err_line), 0);

      // randomized frames: line lengths, line counts, gaps and data
      for (int f = 0; f < 3; f++) begin
         frame_start();
         nl = $urandom_range(V + 2, V - 2);
         for (int r = 0; r < nl; r++) begin
            if ($urandom_range(3, 0) == 0) nb = $urandom_range(2 * H + 5, 2 * H - 5);
            else                           nb = 2 * H;
            send_line(nb, $urandom_range(4, 1));
         end
      end
      frame_start();
      repeat (4) drv(1'b0, 1'b0, 8'h00);
      chk("end_exp_writes_empty", 32'(exp_q.size()), 0);
      chk("end_exp_done_empty", 32'(dq.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
